// File: rtl/uart_transit_pkg.sv
// Shared types and widths for the UART transit path.
// Holds the bridge state encoding and a nibble-select helper.
package uart_transit_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;
    localparam int CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_A  = 3'd1,
        ST_WAIT_A  = 3'd2,
        ST_SEND_B  = 3'd3,
        ST_WAIT_B  = 3'd4,
        ST_TX_WAIT = 3'd5,
        ST_FIRE    = 3'd6
    } bridge_state_t;

    function automatic logic [NIBBLE_W-1:0] pick_nibble(input logic [BYTE_W-1:0] b,
                                                        input logic hi);
        return hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/byte_nibble_bridge.sv
// Byte -> two nibbles to the Hamming encoder, decoded nibbles -> byte to the UART transmitter.
// All outputs are registered from the next-state value, so no input reaches an output combinationally.
//
// state      | meaning
// IDLE       | byte_ready high, waiting for byte_valid
// SEND_A/B   | nibble presented with nib_active for ACTIVE_LEN cycles
// WAIT_A/B   | window closed, waiting for the decoded nibble (timeout)
// TX_WAIT    | byte reassembled, waiting for tx_busy low
// FIRE       | one-cycle tx_enable
module byte_nibble_bridge
    import uart_transit_pkg::*;
#(
    parameter int ACTIVE_LEN = 3,
    parameter int TIMEOUT    = 255,
    parameter bit LO_FIRST   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [NIBBLE_W-1:0] nib_out,
    output logic                nib_active,
    input  logic [NIBBLE_W-1:0] nib_in,
    input  logic                nib_in_valid,
    output logic [BYTE_W-1:0]   tx_byte,
    output logic                tx_enable,
    input  logic                tx_busy,
    output logic [CNT_W-1:0]    ovr_count,
    output logic [CNT_W-1:0]    tmo_count
);

    localparam logic [3:0]       ACT_LOAD = 4'(ACTIVE_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

    bridge_state_t       r_state;
    bridge_state_t       w_state_nxt;
    logic [BYTE_W-1:0]   r_byte;
    logic [3:0]          r_act_cnt;
    logic [CNT_W-1:0]    r_tmo_cnt;
    logic [NIBBLE_W-1:0] r_nib_a;
    logic [NIBBLE_W-1:0] r_nib_b;
    logic                r_cap_a;
    logic                r_cap_b;
    logic                r_byte_ready;
    logic [NIBBLE_W-1:0] r_nib_out;
    logic                r_nib_active;
    logic [BYTE_W-1:0]   r_tx_byte;
    logic                r_tx_enable;

    logic                w_accept;
    logic                w_cap_a_now;
    logic                w_cap_b_now;
    logic                w_win_end;
    logic                w_tmo_exp;
    logic                w_in_wait;
    logic                w_state_change;
    logic                w_ovr_inc;
    logic                w_tmo_inc;
    logic [NIBBLE_W-1:0] w_nib_b;

    // r_byte_ready gates acceptance so the cycle right after reset also counts as not-ready
    assign w_accept       = byte_valid && (r_state == ST_IDLE) && r_byte_ready;
    assign w_cap_a_now    = nib_in_valid && !r_cap_a &&
                            ((r_state == ST_SEND_A) || (r_state == ST_WAIT_A));
    assign w_cap_b_now    = nib_in_valid && !r_cap_b &&
                            ((r_state == ST_SEND_B) || (r_state == ST_WAIT_B));
    assign w_win_end      = (r_act_cnt == '0);
    assign w_tmo_exp      = (r_tmo_cnt == '0);
    assign w_in_wait      = (r_state == ST_WAIT_A) || (r_state == ST_WAIT_B);
    assign w_state_change = (w_state_nxt != r_state);
    assign w_nib_b        = w_cap_b_now ? nib_in : r_nib_b;
    assign w_ovr_inc      = byte_valid && !r_byte_ready;
    assign w_tmo_inc      = w_in_wait && !w_cap_a_now && !w_cap_b_now && w_tmo_exp;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = ST_SEND_A;
            ST_SEND_A:  if (w_win_end) w_state_nxt = (r_cap_a || w_cap_a_now) ? ST_SEND_B : ST_WAIT_A;
            ST_WAIT_A:  if (w_cap_a_now) w_state_nxt = ST_SEND_B;
                        else if (w_tmo_exp) w_state_nxt = ST_IDLE;
            ST_SEND_B:  if (w_win_end) w_state_nxt = (r_cap_b || w_cap_b_now) ? ST_TX_WAIT : ST_WAIT_B;
            ST_WAIT_B:  if (w_cap_b_now) w_state_nxt = ST_TX_WAIT;
                        else if (w_tmo_exp) w_state_nxt = ST_IDLE;
            ST_TX_WAIT: if (!tx_busy) w_state_nxt = ST_FIRE;
            ST_FIRE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_byte       <= '0;
            r_act_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_nib_a      <= '0;
            r_nib_b      <= '0;
            r_cap_a      <= 1'b0;
            r_cap_b      <= 1'b0;
            r_byte_ready <= 1'b0;
            r_nib_out    <= '0;
            r_nib_active <= 1'b0;
            r_tx_byte    <= '0;
            r_tx_enable  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= (w_state_nxt == ST_IDLE);
            r_nib_active <= (w_state_nxt == ST_SEND_A) || (w_state_nxt == ST_SEND_B);
            r_tx_enable  <= (w_state_nxt == ST_FIRE);

            // both timers reload on every state change, which clears the timeout on WAIT entry
            if (w_state_change) begin
                r_act_cnt <= ACT_LOAD;
                r_tmo_cnt <= TMO_LOAD;
            end else begin
                if (r_act_cnt != '0) r_act_cnt <= r_act_cnt - 1'b1;
                if (w_in_wait && (r_tmo_cnt != '0)) r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end

            if (w_accept) begin
                r_byte    <= byte_in;
                r_cap_a   <= 1'b0;
                r_cap_b   <= 1'b0;
                r_nib_out <= pick_nibble(byte_in, !LO_FIRST);
            end
            if (w_cap_a_now) begin
                r_cap_a <= 1'b1;
                r_nib_a <= nib_in;
            end
            if (w_cap_b_now) begin
                r_cap_b <= 1'b1;
                r_nib_b <= nib_in;
            end
            if (w_state_change && (w_state_nxt == ST_SEND_B)) begin
                r_nib_out <= pick_nibble(r_byte, LO_FIRST);
            end
            if (w_state_change && (w_state_nxt == ST_TX_WAIT)) begin
                r_tx_byte <= LO_FIRST ? {w_nib_b, r_nib_a} : {r_nib_a, w_nib_b};
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_ovr_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (w_ovr_inc),
        .count (ovr_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_tmo_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (w_tmo_inc),
        .count (tmo_count)
    );

    assign byte_ready = r_byte_ready;
    assign nib_out    = r_nib_out;
    assign nib_active = r_nib_active;
    assign tx_byte    = r_tx_byte;
    assign tx_enable  = r_tx_enable;

endmodule

// File: tb/tb_byte_nibble_bridge.sv
// Scoreboard bench: two bridges (low-first/TIMEOUT=10 and high-first/TIMEOUT=255),
// directed byte transactions with expected launches, nibble windows and timed probes queued up front.
module tb_byte_nibble_bridge;

    typedef struct {
        int         d;
        logic [7:0] data;
        int         cyc;
    } tx_exp_t;

    typedef struct {
        int         d;
        logic [3:0] nib;
        int         cyc;
    } nib_exp_t;

    typedef struct {
        int d;
        int cyc;
        int kind;
        int ex;
    } probe_t;

    logic       clk;
    logic       rst  [2];
    logic [7:0] bin  [2];
    logic       bv   [2];
    logic [3:0] nin  [2];
    logic       niv  [2];
    logic       busy [2];
    logic       br   [2];
    logic [3:0] nout [2];
    logic       nact [2];
    logic [7:0] txb  [2];
    logic       txe  [2];
    logic [7:0] ovr  [2];
    logic [7:0] tmo  [2];

    logic       pact [2];
    logic [3:0] pnib [2];

    tx_exp_t  txq[$];
    nib_exp_t nq[$];
    probe_t   pq[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    byte_nibble_bridge #(.ACTIVE_LEN(3), .TIMEOUT(10), .LO_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(rst[0]), .byte_in(bin[0]), .byte_valid(bv[0]),
        .byte_ready(br[0]), .nib_out(nout[0]), .nib_active(nact[0]),
        .nib_in(nin[0]), .nib_in_valid(niv[0]), .tx_byte(txb[0]),
        .tx_enable(txe[0]), .tx_busy(busy[0]), .ovr_count(ovr[0]), .tmo_count(tmo[0])
    );

    byte_nibble_bridge #(.ACTIVE_LEN(3), .TIMEOUT(255), .LO_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(rst[1]), .byte_in(bin[1]), .byte_valid(bv[1]),
        .byte_ready(br[1]), .nib_out(nout[1]), .nib_active(nact[1]),
        .nib_in(nin[1]), .nib_in_valid(niv[1]), .tx_byte(txb[1]),
        .tx_enable(txe[1]), .tx_busy(busy[1]), .ovr_count(ovr[1]), .tmo_count(tmo[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int probe_val(input int d, input int kind);
        case (kind)
            0:       return int'(br[d]);
            1:       return int'(tmo[d]);
            2:       return int'(ovr[d]);
            3:       return int'(nact[d]);
            default: return int'(|{br[d], nout[d], nact[d], txb[d], txe[d], ovr[d], tmo[d]});
        endcase
    endfunction

    function automatic string probe_name(input int kind);
        case (kind)
            0:       return "byte_ready";
            1:       return "tmo_count";
            2:       return "ovr_count";
            3:       return "nib_active";
            default: return "reset_outputs_or";
        endcase
    endfunction

    task automatic add_probe(input int d, input int c, input int kind, input int ex);
        pq.push_back('{d, c, kind, ex});
    endtask

    // Monitor: launches and nibble windows pop the scoreboard, timed probes fire on their cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (txe[d] === 1'b1) begin
                int idx;
                idx = -1;
                for (int i = 0; i < txq.size(); i++) if (idx < 0 && txq[i].d == d) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL tx_unexpected dut%0d: got launch of %h at cycle %0d, expected no launch",
                             d, txb[d], cyc);
                end else begin
                    if (txb[d] !== txq[idx].data || cyc != txq[idx].cyc) begin
                        errors++;
                        $display("FAIL tx_launch dut%0d: got %h at cycle %0d, expected %h at cycle %0d",
                                 d, txb[d], cyc, txq[idx].data, txq[idx].cyc);
                    end
                    txq.delete(idx);
                end
            end
            if (nact[d] === 1'b1 && (pact[d] !== 1'b1 || nout[d] !== pnib[d])) begin
                int idx;
                idx = -1;
                for (int i = 0; i < nq.size(); i++) if (idx < 0 && nq[i].d == d) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL nib_unexpected dut%0d: got window nibble %h at cycle %0d, expected none",
                             d, nout[d], cyc);
                end else begin
                    if (nout[d] !== nq[idx].nib || cyc != nq[idx].cyc) begin
                        errors++;
                        $display("FAIL nib_window dut%0d: got %h at cycle %0d, expected %h at cycle %0d",
                                 d, nout[d], cyc, nq[idx].nib, nq[idx].cyc);
                    end
                    nq.delete(idx);
                end
            end
            pact[d] = nact[d];
            pnib[d] = nout[d];
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].cyc == cyc) begin
                int v;
                v = probe_val(pq[i].d, pq[i].kind);
                checks++;
                if (v != pq[i].ex) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d",
                             probe_name(pq[i].kind), pq[i].d, cyc, v, pq[i].ex);
                end
                pq.delete(i);
            end
        end
    end

    // One byte transaction; k counts cycles from the byte_valid cycle. The codec loops nib_out back.
    task automatic send_byte(input int d, input logic [7:0] b, input int da, input int db,
                             input int nwin, input int fire, input int busy_until,
                             input int bv_from, input int bv_to, input int rst_at, input int ncyc);
        int t0;
        t0 = cyc;
        if (fire >= 0) txq.push_back('{d, b, t0 + fire});
        nq.push_back('{d, (d == 0) ? b[3:0] : b[7:4], t0 + 1});
        if (nwin > 1)
            nq.push_back('{d, (d == 0) ? b[7:4] : b[3:0],
                           t0 + ((da >= 0 && da <= 3) ? 4 : da + 1)});
        for (int k = 0; k < ncyc; k++) begin
            bv[d]   = (k == 0) || (k >= bv_from && k <= bv_to);
            bin[d]  = b;
            niv[d]  = (k == da) || (k == db);
            nin[d]  = nout[d];
            busy[d] = (k < busy_until);
            rst[d]  = (rst_at >= 0 && k >= rst_at && k < rst_at + 2);
            @(negedge clk);
        end
        bv[d]   = 1'b0;
        niv[d]  = 1'b0;
        busy[d] = 1'b0;
        rst[d]  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 50000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; bin[d] = '0; bv[d] = 1'b0; nin[d] = '0;
            niv[d] = 1'b0; busy[d] = 1'b0; pact[d] = 1'b0; pnib[d] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        add_probe(0, cyc + 1, 4, 0);
        add_probe(1, cyc + 1, 4, 0);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        add_probe(0, cyc + 1, 0, 1);
        add_probe(1, cyc + 1, 0, 1);
        repeat (3) @(negedge clk);

        // loopback 0xA5, low nibble first then high nibble first
        t0 = cyc;
        add_probe(0, t0 + 8, 0, 0);
        add_probe(0, t0 + 9, 0, 1);
        send_byte(0, 8'hA5, 2, 5, 2, 8, 0, -1, -2, -1, 12);
        send_byte(1, 8'hA5, 2, 5, 2, 8, 0, -1, -2, -1, 12);

        // nibble B returned 20 cycles after its window closes
        t0 = cyc;
        add_probe(1, t0 + 15, 3, 0);
        add_probe(1, t0 + 15, 0, 0);
        add_probe(1, t0 + 30, 1, 0);
        send_byte(1, 8'h5A, 2, 26, 2, 28, 0, -1, -2, -1, 32);

        // no decoded nibble: abandon after ACTIVE_LEN+TIMEOUT, back in IDLE at cycle 14
        t0 = cyc;
        add_probe(0, t0 + 13, 0, 0);
        add_probe(0, t0 + 13, 1, 0);
        add_probe(0, t0 + 14, 0, 1);
        add_probe(0, t0 + 14, 1, 1);
        send_byte(0, 8'h42, -1, -1, 1, -1, 0, -1, -2, -1, 18);
        send_byte(0, 8'h3C, 2, 5, 2, 8, 0, -1, -2, -1, 12);

        // transmitter busy until cycle 57, three overrun strobes during the hold
        t0 = cyc;
        add_probe(0, t0 + 57, 0, 0);
        add_probe(0, t0 + 60, 2, 3);
        send_byte(0, 8'h7E, 2, 5, 2, 58, 57, 10, 12, -1, 62);

        // reset during SEND_B (cycles 5-6): everything clears, no launch
        t0 = cyc;
        add_probe(0, t0 + 6, 4, 0);
        add_probe(0, t0 + 7, 4, 0);
        add_probe(0, t0 + 8, 0, 1);
        send_byte(0, 8'h96, 2, -1, 2, -1, 0, -1, -2, 5, 12);

        // 300 overrun strobes while the transmitter is held busy
        t0 = cyc;
        add_probe(0, t0 + 210, 2, 200);
        add_probe(0, t0 + 300, 2, 255);
        add_probe(0, t0 + 323, 2, 255);
        send_byte(0, 8'h81, 2, 5, 2, 321, 320, 10, 309, -1, 325);

        repeat (3) @(negedge clk);
        checks++;
        if (txq.size() != 0 || nq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d launches, %0d windows, %0d probes pending, expected 0",
                     txq.size(), nq.size(), pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
